register_file_scoreboard: RTL and testbench



---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 42 ++++
 rtl/register_file_scoreboard.sv | 89 ++++++++
 tb/tb_register_file_scoreboard.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and read-port types for the register file and its pending-write scoreboard.
// No logic here, so there is no latency and no backpressure.
package regfile_pkg;
  localparam int ZERO_REG      = 0;
  localparam int DEFAULT_N     = 32;
  localparam int DEFAULT_DEPTH = 32;
  localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

  typedef logic [DEFAULT_AW-1:0] rd_req_t;

  typedef struct packed {
    logic [DEFAULT_N-1:0] data;
    logic                 busy;
  } rd_rsp_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: reserve sets a bit, writeback clears it, and two lookups are combinational.
// The set/clear takes effect in 1 cycle, and there is no backpressure. REGFILE_BYPASS_EN selects whether lookups see same-edge writes.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_set_vld,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr_vld,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_lk1_addr,
  input  logic [ADDR_W-1:0] i_lk2_addr,
  output logic              o_busy1,
  output logic              o_busy2
);
  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_set_mask;
  logic [DEPTH-1:0] w_clr_mask;
  logic [DEPTH-1:0] w_next;

  assign w_set_mask = i_set_vld ? (DEPTH'(1) << i_set_addr) : '0;
  assign w_clr_mask = i_clr_vld ? (DEPTH'(1) << i_clr_addr) : '0;
  // Set is applied after clear so a new producer wins over the retiring one; bit 0 never pends.
  assign w_next     = ((r_pend & ~w_clr_mask) | w_set_mask) & ~DEPTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pend <= '0;
    else        r_pend <= w_next;
  end

`ifdef REGFILE_BYPASS_EN
  assign o_busy1 = w_next[i_lk1_addr];
  assign o_busy2 = w_next[i_lk2_addr];
`else
  assign o_busy1 = r_pend[i_lk1_addr] | w_set_mask[i_lk1_addr];
  assign o_busy2 = r_pend[i_lk2_addr] | w_set_mask[i_lk2_addr];
`endif
endmodule

// File: rtl/register_file_scoreboard.sv
// Two-read/one-write register file with registered reads and per-register busy flags; r0 is hardwired to 0.
// Reads and writes take 1 cycle, and there is no backpressure. REGFILE_BYPASS_EN forwards a same-edge write to the reads.
module register_file_scoreboard
  import regfile_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Reg_Write_i,
  input  logic [ADDR_W-1:0] Write_Register_i,
  input  logic [N-1:0]      Write_Data_i,
  input  logic [ADDR_W-1:0] Read_Register_1_i,
  input  logic [ADDR_W-1:0] Read_Register_2_i,
  input  logic              Reserve_i,
  input  logic [ADDR_W-1:0] Reserve_Register_i,
  output logic [N-1:0]      Read_Data_1_o,
  output logic [N-1:0]      Read_Data_2_o,
  output logic              Busy_1_o,
  output logic              Busy_2_o
);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [N-1:0] r_mem [DEPTH];
  logic [N-1:0] r_rd1;
  logic [N-1:0] r_rd2;
  logic         r_busy1;
  logic         r_busy2;
  logic         w_we;
  logic         w_rsv;
  logic [N-1:0] w_rd1;
  logic [N-1:0] w_rd2;
  logic         w_busy1;
  logic         w_busy2;

  assign w_we  = Reg_Write_i && (Write_Register_i != ZERO_ADDR);
  assign w_rsv = Reserve_i && (Reserve_Register_i != ZERO_ADDR);

  regfile_scoreboard #(.DEPTH(DEPTH)) u_sb (
    .clk        (clk),
    .reset      (reset),
    .i_set_vld  (w_rsv),
    .i_set_addr (Reserve_Register_i),
    .i_clr_vld  (w_we),
    .i_clr_addr (Write_Register_i),
    .i_lk1_addr (Read_Register_1_i),
    .i_lk2_addr (Read_Register_2_i),
    .o_busy1    (w_busy1),
    .o_busy2    (w_busy2)
  );

  always_comb begin
    w_rd1 = (Read_Register_1_i == ZERO_ADDR) ? '0 : r_mem[Read_Register_1_i];
    w_rd2 = (Read_Register_2_i == ZERO_ADDR) ? '0 : r_mem[Read_Register_2_i];
`ifdef REGFILE_BYPASS_EN
    if (w_we && (Write_Register_i == Read_Register_1_i)) w_rd1 = Write_Data_i;
    if (w_we && (Write_Register_i == Read_Register_2_i)) w_rd2 = Write_Data_i;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[Write_Register_i] <= Write_Data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_busy1 <= 1'b0;
      r_busy2 <= 1'b0;
    end else begin
      r_rd1   <= w_rd1;
      r_rd2   <= w_rd2;
      r_busy1 <= w_busy1;
      r_busy2 <= w_busy2;
    end
  end

  assign Read_Data_1_o = r_rd1;
  assign Read_Data_2_o = r_rd2;
  assign Busy_1_o      = r_busy1;
  assign Busy_2_o      = r_busy2;
endmodule

// File: tb/tb_register_file_scoreboard.sv
// Randomised and directed bench for register_file_scoreboard against an array/flag model of the register file.
module tb_register_file_scoreboard;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic        rs = 1'b0;
  logic [4:0]  rsa = '0;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        b1;
  logic        b2;

  logic [31:0] mem [32];
  logic        pend [32];
  rd_rsp_t     exp1;
  rd_rsp_t     exp2;
  int          checks = 0;
  int          errors = 0;

  register_file_scoreboard dut (
    .clk                (clk),
    .reset              (reset),
    .Reg_Write_i        (we),
    .Write_Register_i   (wa),
    .Write_Data_i       (wd),
    .Read_Register_1_i  (ra1),
    .Read_Register_2_i  (ra2),
    .Reserve_i          (rs),
    .Reserve_Register_i (rsa),
    .Read_Data_1_o      (rd1),
    .Read_Data_2_o      (rd2),
    .Busy_1_o           (b1),
    .Busy_2_o           (b2)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem[i]  = '0;
      pend[i] = 1'b0;
    end
  endtask

  function automatic rd_rsp_t predict(input logic [4:0] a);
    rd_rsp_t r;
    r.data = (a == 0) ? 32'd0 : mem[a];
    r.busy = pend[a];
`ifdef REGFILE_BYPASS_EN
    if (we && wa != 0 && wa == a) begin
      r.data = wd;
      r.busy = 1'b0;
    end
`endif
    if (rs && rsa != 0 && rsa == a) r.busy = 1'b1;
    return r;
  endfunction

  // Applies one cycle of stimulus, predicts the outputs, and advances the model past the edge.
  task automatic cycle(input logic w, input logic [4:0] wadr, input logic [31:0] wdat,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic r, input logic [4:0] radr);
    we = w; wa = wadr; wd = wdat; ra1 = a1; ra2 = a2; rs = r; rsa = radr;
    exp1 = predict(a1);
    exp2 = predict(a2);
    @(posedge clk);
    #1;
    if (w && wadr != 0) begin
      mem[wadr]  = wdat;
      pend[wadr] = 1'b0;
    end
    if (r && radr != 0) pend[radr] = 1'b1;
    we = 1'b0; rs = 1'b0;
  endtask

  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rd1, rd2, b1, b2} !== 66'd0)
      $display("FAIL reset_hold got %h want 0", {rd1, rd2, b1, b2});
    if ({rd1, rd2, b1, b2} !== 66'd0) errors++;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    cycle(0, 0, 0, 0, 5, 0, 0);
    checks++;
    if ({rd1, b1, rd2, b2} !== {exp1, exp2} || {rd1, rd2, b1, b2} !== 66'd0) begin
      errors++;
      $display("FAIL reset_read_0_5 got %h/%b %h/%b want 0", rd1, b1, rd2, b2);
    end
    cycle(0, 0, 0, 31, 31, 0, 0);
    checks++;
    if ({rd1, rd2, b1, b2} !== 66'd0) begin
      errors++;
      $display("FAIL reset_read_31 got %h/%b %h/%b want 0", rd1, b1, rd2, b2);
    end
  endtask

  task automatic test_write_read();
    cycle(1, 2, 32'd7, 0, 0, 0, 0);
    cycle(0, 0, 0, 2, 2, 0, 0);
    checks++;
    if (rd1 !== 32'd7 || rd2 !== 32'd7 || b1 !== 1'b0 || b2 !== 1'b0) begin
      errors++;
      $display("FAIL write_read r2 got %0d/%0d busy %b%b want 7/7 busy 00", rd1, rd2, b1, b2);
    end
  endtask

  task automatic test_reg0();
    cycle(1, 0, 32'd3, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({rd1, rd2, b1, b2} !== 66'd0) begin
      errors++;
      $display("FAIL reg0 got %h/%b want 0/0", rd1, b1);
    end
  endtask

  task automatic test_bypass();
    cycle(1, 4, 32'd20, 4, 0, 0, 0);
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (rd1 !== 32'd20) begin
`else
    if (rd1 !== 32'd0) begin
`endif
      errors++;
      $display("FAIL bypass_same_edge got %0d want %0d", rd1, exp1.data);
    end
    cycle(0, 0, 0, 4, 4, 0, 0);
    checks++;
    if (rd1 !== 32'd20 || rd2 !== 32'd20) begin
      errors++;
      $display("FAIL bypass_next_read got %0d/%0d want 20/20", rd1, rd2);
    end
  endtask

  task automatic test_scoreboard();
    cycle(0, 0, 0, 0, 0, 1, 25);
    cycle(0, 0, 0, 25, 25, 0, 0);
    checks++;
    if (b1 !== 1'b1 || b2 !== 1'b1) begin
      errors++;
      $display("FAIL sb_reserved got busy %b%b want 11", b1, b2);
    end
    cycle(1, 25, 32'd6, 0, 0, 0, 0);
    cycle(0, 0, 0, 25, 0, 0, 0);
    checks++;
    if (b1 !== 1'b0 || rd1 !== 32'd6) begin
      errors++;
      $display("FAIL sb_cleared got %0d busy %b want 6 busy 0", rd1, b1);
    end
  endtask

  task automatic test_simul_reset();
    cycle(1, 31, 32'd78, 0, 0, 1, 31);
    cycle(0, 0, 0, 31, 31, 0, 0);
    checks++;
    if (rd1 !== 32'd78 || b1 !== 1'b1 || rd2 !== 32'd78 || b2 !== 1'b1) begin
      errors++;
      $display("FAIL simul_rsv_wr got %0d busy %b want 78 busy 1", rd1, b1);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({rd1, rd2, b1, b2} !== 66'd0) begin
      errors++;
      $display("FAIL async_reset got %h want 0", {rd1, rd2, b1, b2});
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cycle(0, 0, 0, 31, 31, 0, 0);
    checks++;
    if ({rd1, rd2, b1, b2} !== 66'd0) begin
      errors++;
      $display("FAIL post_reset_r31 got %0d busy %b want 0 busy 0", rd1, b1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), rnd_addr(), $urandom(), rnd_addr(), rnd_addr(),
            1'($urandom_range(0, 2) == 0), rnd_addr());
      checks++;
      if ({rd1, b1, rd2, b2} !== {exp1, exp2}) begin
        errors++;
        $display("FAIL random[%0d] got %h/%b %h/%b want %h/%b %h/%b", n,
                 rd1, b1, rd2, b2, exp1.data, exp1.busy, exp2.data, exp2.busy);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_reg0();
    test_bypass();
    test_scoreboard();
    test_simul_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
